// File: rtl/wiener_pkg.sv
// Shared types and defaults for the Wiener filter block scheduler and its
// companion datapath.
package wiener_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_TOTAL_SAMPLES = 64;

  typedef logic [2*DEF_DATA_WIDTH-1:0] stat_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_STATS,
    PREFETCH,
    STREAM,
    NEXT
  } sched_state_t;

endpackage

// File: rtl/wiener_sample_counter.sv
// Modulo-N sample counter with synchronous clear/enable and a flag that
// marks the final sample index (N-1).
module wiener_sample_counter #(
  parameter int N = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int                 W    = $clog2(N);
  localparam logic [W-1:0]       LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  assign last_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wiener_block_sched.sv
// Block sequencer in front of wiener_calc: latches frame/block statistics and
// streams one contiguous block of pixels per stats handshake.
// Optional frame cycle counter enabled by defining WIENER_SCHED_PERF_EN.
module wiener_block_sched
  import wiener_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int TOTAL_SAMPLES = DEF_TOTAL_SAMPLES,
  parameter int LEVEL_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             blocks_per_frame,
  input  logic                    noise_valid,
  input  logic [2*DATA_WIDTH-1:0] noise_variance_in,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [2*DATA_WIDTH-1:0] mean_in,
  input  logic [2*DATA_WIDTH-1:0] variance_in,
  input  logic                    pix_valid,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic [LEVEL_WIDTH-1:0]  pix_level,
  output logic                    pix_ready,
  output logic                    stats_ready,
  output logic [2*DATA_WIDTH-1:0] mean_of_block,
  output logic [2*DATA_WIDTH-1:0] variance_of_block,
  output logic [2*DATA_WIDTH-1:0] noise_variance,
  output logic [DATA_WIDTH-1:0]   data_in,
  output logic [31:0]             block_idx,
  output logic                    frame_done,
  output logic                    underrun,
  output logic                    busy,
  output logic [31:0]             frame_cycles
);

  localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL = LEVEL_WIDTH'(TOTAL_SAMPLES);

  sched_state_t state_q, state_d;

  logic [2*DATA_WIDTH-1:0] noise_q, mean_q, var_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [31:0]             block_idx_q, bpf_last_q;
  logic                    stats_ready_q, frame_done_q, underrun_q;

  logic pop, cnt_clr, cnt_last;
  logic start_frame, take_stats, next_blk, end_frame;

  wiener_sample_counter #(.N(TOTAL_SAMPLES)) u_sample_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (pop),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The PREFETCH pop moves the counter to 1, so STREAM pops samples 1..N-1
  // and the counter's last flag marks the final pop of the block.
  always_comb begin
    state_d     = state_q;
    st_ready    = 1'b0;
    pop         = 1'b0;
    cnt_clr     = 1'b0;
    start_frame = 1'b0;
    take_stats  = 1'b0;
    next_blk    = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      IDLE: begin
        if (noise_valid) begin
          start_frame = 1'b1;
          state_d     = WAIT_STATS;
        end
      end
      WAIT_STATS: begin
        st_ready = 1'b1;
        cnt_clr  = 1'b1;
        if (st_valid) begin
          take_stats = 1'b1;
          state_d    = PREFETCH;
        end
      end
      PREFETCH: begin
        if (pix_level >= LEVEL_FULL) begin
          pop     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        pop = 1'b1;
        if (cnt_last) state_d = NEXT;
      end
      NEXT: begin
        if (block_idx_q == bpf_last_q) begin
          end_frame = 1'b1;
          state_d   = IDLE;
        end else begin
          next_blk = 1'b1;
          state_d  = WAIT_STATS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_ready = pop;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noise_q       <= '0;
      mean_q        <= '0;
      var_q         <= '0;
      data_q        <= '0;
      block_idx_q   <= '0;
      bpf_last_q    <= '0;
      stats_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      stats_ready_q <= pop && (state_q == PREFETCH);
      frame_done_q  <= end_frame;
      if (start_frame) begin
        noise_q    <= noise_variance_in;
        bpf_last_q <= (blocks_per_frame == 32'd0) ? 32'd0 : blocks_per_frame - 32'd1;
      end
      if (take_stats) begin
        mean_q <= mean_in;
        var_q  <= variance_in;
      end
      // A missing pixel still consumes a slot so the block length never stretches.
      if (pop) begin
        if (pix_valid) data_q <= pix_in;
        else           underrun_q <= 1'b1;
      end
      if (start_frame || end_frame) begin
        block_idx_q <= '0;
      end else if (next_blk) begin
        block_idx_q <= block_idx_q + 32'd1;
      end
    end
  end

  assign stats_ready       = stats_ready_q;
  assign frame_done        = frame_done_q;
  assign underrun          = underrun_q;
  assign mean_of_block     = mean_q;
  assign variance_of_block = var_q;
  assign noise_variance    = noise_q;
  assign data_in           = data_q;
  assign block_idx         = block_idx_q;

`ifdef WIENER_SCHED_PERF_EN
  logic [31:0] perf_cnt_q, frame_cycles_q;

  // The reported figure includes the frame_done cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q     <= '0;
      frame_cycles_q <= '0;
    end else if (frame_done_q) begin
      frame_cycles_q <= perf_cnt_q + 32'd1;
      perf_cnt_q     <= '0;
    end else if (busy) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign frame_cycles = frame_cycles_q;
`else
  assign frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_wiener_block_sched.sv
// Self-checking bench for wiener_block_sched: table of frame scenarios,
// randomized frames, and a mid-stream reset sequence.
module tb_wiener_block_sched;
  import wiener_pkg::*;

  localparam int T = 64;
`ifdef WIENER_SCHED_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd67;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] blocks_per_frame;
  logic        noise_valid;
  stat_t       noise_variance_in;
  logic        st_valid, st_ready;
  stat_t       mean_in, variance_in;
  logic        pix_valid;
  logic [7:0]  pix_in, pix_level;
  logic        pix_ready, stats_ready;
  stat_t       mean_of_block, variance_of_block, noise_variance;
  logic [7:0]  data_in;
  logic [31:0] block_idx;
  logic        frame_done, underrun, busy;
  logic [31:0] frame_cycles;

  always #5 clk = ~clk;

  wiener_block_sched #(.DATA_WIDTH(8), .TOTAL_SAMPLES(T), .LEVEL_WIDTH(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .blocks_per_frame  (blocks_per_frame),
    .noise_valid       (noise_valid),
    .noise_variance_in (noise_variance_in),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .mean_in           (mean_in),
    .variance_in       (variance_in),
    .pix_valid         (pix_valid),
    .pix_in            (pix_in),
    .pix_level         (pix_level),
    .pix_ready         (pix_ready),
    .stats_ready       (stats_ready),
    .mean_of_block     (mean_of_block),
    .variance_of_block (variance_of_block),
    .noise_variance    (noise_variance),
    .data_in           (data_in),
    .block_idx         (block_idx),
    .frame_done        (frame_done),
    .underrun          (underrun),
    .busy              (busy),
    .frame_cycles      (frame_cycles)
  );

  typedef struct {
    int         bpf;
    logic [15:0] noise;
    int         fixed;
    int         hold;
    int         drop;
    int         stall;
    int         exp_blocks;
    logic       exp_unr;
  } vec_t;

  int          tests = 0, fails = 0;
  logic [7:0]  fifo[$];
  logic [7:0]  exp_px[$];
  int          pops_in_blk = 0, drop_at = -1;
  logic        acc_seen = 1'b0;
  int          cap_idx = T, pulses = 0, fd_count = 0, frame_blocks = 1;
  bit          fd_pending = 0, mon_en = 0;
  logic [15:0] exp_mean[8], exp_var[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    pix_level = 8'(fifo.size());
    pix_valid = (fifo.size() > 0) && !(drop_at >= 0 && pops_in_blk == drop_at);
    pix_in    = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  // Reference checks on observed outputs, sampled at the falling edge.
  task automatic monitor();
    if (!mon_en) return;
    check("frame_done_timing", {63'd0, frame_done}, {63'd0, fd_pending});
    fd_pending = 0;
    if (frame_done) fd_count++;
    if (stats_ready) begin
      check("block_idx", block_idx, pulses);
      if (pulses < 8) begin
        check("mean_of_block", mean_of_block, exp_mean[pulses]);
        check("variance_of_block", variance_of_block, exp_var[pulses]);
      end
      check("st_ready_in_stream", {63'd0, st_ready}, 64'd0);
      pulses++;
      cap_idx = 0;
    end
    if (cap_idx < T) begin
      if (exp_px.size() == 0) begin
        tests++; fails++;
        $display("FAIL data_in_extra: got 0x%0h, expected no pixel", data_in);
      end else begin
        check("data_in", data_in, exp_px.pop_front());
      end
      cap_idx++;
      if (cap_idx == T && pulses == frame_blocks) fd_pending = 1;
    end
  endtask

  task automatic tick();
    bit rdy;
    @(negedge clk);
    monitor();
    rdy      = pix_ready;
    acc_seen = st_ready && st_valid;
    @(posedge clk);
    #1;
    if (rdy) begin
      if (pix_valid) void'(fifo.pop_front());
      pops_in_blk++;
    end
    drive_fifo();
  endtask

  task automatic run_block(input int blk, input int fixed, input int hold, input int drop, input int stall);
    logic [7:0] p[T];
    int n;
    for (int i = 0; i < T; i++) p[i] = fixed ? 8'(8'hC0 + i) : 8'($urandom);
    // With a missing pixel at index d, every later slot shows the pixel one earlier.
    for (int k = 0; k < T; k++) begin
      if (drop < 0 || k < drop) exp_px.push_back(p[k]);
      else                      exp_px.push_back(p[k-1]);
    end
    fifo.delete();
    pops_in_blk = 0;
    drop_at     = drop;
    for (int i = 0; i < T - ((hold > 0) ? 1 : 0); i++) fifo.push_back(p[i]);
    drive_fifo();
    repeat (stall) tick();
    st_valid    = 1'b1;
    mean_in     = exp_mean[blk];
    variance_in = exp_var[blk];
    n = 0;
    do begin tick(); n++; end while (!acc_seen && n < 200);
    if (!acc_seen) begin tests++; fails++; $display("FAIL st_handshake_timeout: got no accept, expected one"); end
    st_valid    = 1'b0;
    mean_in     = 16'($urandom);
    variance_in = 16'($urandom);
    if (hold > 0) begin
      repeat (hold) begin
        tick();
        check("level_gate", {63'd0, pix_ready}, 64'd0);
      end
      fifo.push_back(p[T-1]);
      drive_fifo();
      #1;
      check("level_release", {63'd0, pix_ready}, 64'd1);
    end
    n = 0;
    while (!(pulses >= blk + 1 && cap_idx == T) && n < 300) begin tick(); n++; end
    check("block_streamed", pulses, blk + 1);
    fifo.delete();
    drop_at = -1;
    drive_fifo();
  endtask

  task automatic run_frame(input vec_t v, input bit chk_perf);
    int n;
    frame_blocks = v.exp_blocks;
    pulses = 0; fd_count = 0; cap_idx = T; fd_pending = 0; mon_en = 1;
    exp_px.delete();
    check("busy_before", {63'd0, busy}, 64'd0);
    blocks_per_frame  = v.bpf;
    noise_valid       = 1'b1;
    noise_variance_in = v.noise;
    tick();
    noise_valid       = 1'b0;
    noise_variance_in = 16'($urandom);
    blocks_per_frame  = $urandom_range(1, 5);
    check("busy_running", {63'd0, busy}, 64'd1);
    check("noise_variance", noise_variance, v.noise);
    for (int b = 0; b < v.exp_blocks && b < 8; b++) begin
      exp_mean[b] = v.fixed ? 16'h0080 : 16'($urandom);
      exp_var[b]  = v.fixed ? 16'h0040 : 16'($urandom);
      run_block(b, v.fixed, v.hold, (b == 0) ? v.drop : -1, v.stall);
    end
    n = 0;
    while (fd_count == 0 && n < 10) begin tick(); n++; end
    check("frame_done_count", fd_count, 1);
    check("stats_pulses", pulses, v.exp_blocks);
    check("busy_after", {63'd0, busy}, 64'd0);
    check("underrun", {63'd0, underrun}, {63'd0, v.exp_unr});
    if (chk_perf) check("frame_cycles", frame_cycles, PERF_EXP);
    tick();
    check("frame_done_single", fd_count, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_st_ready"}, {63'd0, st_ready}, 64'd0);
    check({tag, "_pix_ready"}, {63'd0, pix_ready}, 64'd0);
    check({tag, "_stats_ready"}, {63'd0, stats_ready}, 64'd0);
    check({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    check({tag, "_underrun"}, {63'd0, underrun}, 64'd0);
    check({tag, "_data_in"}, data_in, 64'd0);
    check({tag, "_block_idx"}, block_idx, 64'd0);
    check({tag, "_stats"}, {mean_of_block, variance_of_block, noise_variance}, 64'd0);
    check({tag, "_frame_cycles"}, frame_cycles, 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    vec_t rv;
    vecs[0] = '{1, 16'h0020, 1,  0, -1, 0, 1, 1'b0};
    vecs[1] = '{1, 16'h0031, 0, 20, -1, 1, 1, 1'b0};
    vecs[2] = '{3, 16'h0042, 0,  0, -1, 2, 3, 1'b0};
    vecs[3] = '{0, 16'h0053, 0,  0, -1, 0, 1, 1'b0};
    vecs[4] = '{2, 16'h0064, 0,  0, 10, 0, 2, 1'b1};

    blocks_per_frame = 32'd1; noise_valid = 1'b0; noise_variance_in = '0;
    st_valid = 1'b0; mean_in = '0; variance_in = '0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i == 0);

    for (int i = 0; i < 4; i++) begin
      rv.bpf        = $urandom_range(0, 3);
      rv.noise      = 16'($urandom);
      rv.fixed      = 0;
      rv.hold       = $urandom_range(0, 3);
      rv.drop       = -1;
      rv.stall      = $urandom_range(0, 3);
      rv.exp_blocks = (rv.bpf == 0) ? 1 : rv.bpf;
      rv.exp_unr    = 1'b1;
      run_frame(rv, 0);
    end

    // Reset while sample 30 is being popped.
    mon_en = 0;
    blocks_per_frame  = 32'd1;
    noise_valid       = 1'b1;
    noise_variance_in = 16'h0077;
    tick();
    noise_valid = 1'b0;
    fifo.delete();
    for (int i = 0; i < T; i++) fifo.push_back(8'($urandom));
    pops_in_blk = 0; drop_at = -1;
    drive_fifo();
    st_valid = 1'b1; mean_in = 16'h1234; variance_in = 16'h5678;
    n = 0;
    do begin tick(); n++; end while (!acc_seen && n < 50);
    st_valid = 1'b0;
    n = 0;
    while (pops_in_blk < 30 && n < 200) begin tick(); n++; end
    check("rst_reach_s30", pops_in_blk, 30);
    check("rst_pre_busy", {63'd0, busy}, 64'd1);
    check("underrun_sticky", {63'd0, underrun}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fifo.delete();
    exp_px.delete();
    drive_fifo();

    run_frame(vecs[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
